// File: rtl/knn_mem_pkg.sv
// Shared constants and memory command type for the kNN local URAM buffer.
package knn_mem_pkg;

  localparam int KNN_DATA_WIDTH = 256;
  localparam int KNN_ADDR_WIDTH = 11;

  typedef struct packed {
    logic [KNN_ADDR_WIDTH-1:0] addr;
    logic [KNN_DATA_WIDTH-1:0] data;
    logic                      we;
    logic                      ce;
  } mem_cmd_t;

endpackage

// File: rtl/knn_resp_fifo.sv
// Show-ahead response FIFO: dout always presents the head entry while not empty.
module knn_resp_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = store[rd_ptr];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/knn_local_mem_arbiter.sv
// Single-port URAM arbiter: read/write sharing, read-latency tagging, credited response FIFO.
// Define KNN_ARB_RR_EN for round-robin arbitration; default is fixed read-over-write priority.
module knn_local_mem_arbiter
  import knn_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = KNN_DATA_WIDTH,
  parameter int ADDR_WIDTH   = KNN_ADDR_WIDTH,
  parameter int READ_LATENCY = 2,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_address0,
  output logic                  mem_ce0,
  output logic                  mem_we0,
  output logic [DATA_WIDTH-1:0] mem_d0,
  input  logic [DATA_WIDTH-1:0] mem_q0
);

  localparam int CW = $clog2(RESP_DEPTH + 1);

  mem_cmd_t                cmd_q;
  logic [CW-1:0]           credits;
  logic [READ_LATENCY-1:0] inflight;
  logic                    active;
  logic                    rd_elig, rd_acc, wr_acc;
  logic                    rsp_push, rsp_pop, fifo_full, fifo_empty;

  assign rd_elig = rd_valid && (credits != '0);
  assign rd_acc  = rd_valid && rd_ready;
  assign wr_acc  = wr_valid && wr_ready;

`ifdef KNN_ARB_RR_EN
  logic wr_elig, pick_wr;

  assign wr_elig  = wr_valid;
  assign rd_ready = active && rd_elig && (!wr_elig || !pick_wr);
  assign wr_ready = active && wr_elig && (!rd_elig || pick_wr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    pick_wr <= 1'b0;
    else if (rd_acc) pick_wr <= 1'b1;
    else if (wr_acc) pick_wr <= 1'b0;
  end
`else
  assign rd_ready = active && (credits != '0);
  assign wr_ready = active && !rd_elig;
`endif

  // A credit comes back the cycle after its pop, so the loop is READ_LATENCY+3 cycles long.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q    <= '0;
      active   <= 1'b0;
      credits  <= CW'(RESP_DEPTH);
      inflight <= '0;
    end else begin
      active   <= 1'b1;
      cmd_q.ce <= rd_acc || wr_acc;
      cmd_q.we <= wr_acc;
      if (rd_acc)      cmd_q.addr <= KNN_ADDR_WIDTH'(rd_addr);
      else if (wr_acc) cmd_q.addr <= KNN_ADDR_WIDTH'(wr_addr);
      if (wr_acc)      cmd_q.data <= KNN_DATA_WIDTH'(wr_data);
      inflight <= (inflight << 1) | READ_LATENCY'(cmd_q.ce && !cmd_q.we);
      case ({rd_acc, rsp_pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  assign mem_address0 = cmd_q.addr[ADDR_WIDTH-1:0];
  assign mem_d0       = cmd_q.data[DATA_WIDTH-1:0];
  assign mem_ce0      = cmd_q.ce;
  assign mem_we0      = cmd_q.we;

  assign rsp_push  = inflight[READ_LATENCY-1];
  assign rsp_valid = !fifo_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;

  knn_resp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rsp_push),
    .din     (mem_q0),
    .pop     (rsp_pop),
    .dout    (rsp_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assert property (@(posedge clk) disable iff (!reset_n) !(rsp_push && fifo_full && !rsp_pop));

endmodule

// File: tb/tb_knn_local_mem_arbiter.sv
// Self-checking bench for knn_local_mem_arbiter against a credit/delay-queue reference model.
module tb_knn_local_mem_arbiter;

  localparam int RSP_LAT = 4;
  localparam int DEPTH   = 4;

  logic         clk, reset_n;
  logic         wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
  logic [10:0]  wr_addr, rd_addr, mem_address0;
  logic [255:0] wr_data, rsp_data, mem_d0, mem_q0;
  logic         mem_ce0, mem_we0;

  knn_local_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0),
    .mem_d0(mem_d0), .mem_q0(mem_q0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // URAM model: two-cycle read latency, garbage on q0 when not reading
  logic [255:0] tmem [0:2047];
  logic [255:0] p1;
  always @(posedge clk) begin
    if (mem_ce0 && mem_we0) tmem[mem_address0] <= mem_d0;
    p1     <= (mem_ce0 && !mem_we0) ? tmem[mem_address0] : rnd256();
    mem_q0 <= p1;
  end

  typedef struct { int avail; logic [255:0] data; } rsp_t;
  rsp_t         exp_q[$];
  logic [255:0] ref_mem [0:2047];
  logic [255:0] b2b [16];
  int           m_credits, now;
  logic         m_last_rd;
  int           tests = 0, fails = 0;

  logic         o_rd_ready, o_wr_ready, o_rsp_valid, o_we0, o_acc_rd, o_acc_wr;
  logic [255:0] o_rsp_data, e_rsp_data;
  logic         e_rd_ready, e_wr_ready, e_rsp_valid, m_acc_rd, m_acc_wr;

  task automatic model_reset();
    exp_q.delete();
    m_credits = DEPTH;
    m_last_rd = 1'b0;
  endtask

  // One clock: drive, observe, advance model. Entered and left just after a negedge.
  task automatic cycle(input logic rv, input logic [10:0] ra, input logic wv,
                       input logic [10:0] wa, input logic [255:0] wd, input logic pr);
    rd_valid = rv; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd; rsp_ready = pr;
    #1;
`ifdef KNN_ARB_RR_EN
    e_rd_ready = rv && m_credits > 0 && (!wv || !m_last_rd);
    e_wr_ready = wv && (!(rv && m_credits > 0) || m_last_rd);
`else
    e_rd_ready = m_credits > 0;
    e_wr_ready = !(rv && m_credits > 0);
`endif
    e_rsp_valid = exp_q.size() > 0 && exp_q[0].avail <= now;
    e_rsp_data  = e_rsp_valid ? exp_q[0].data : '0;
    o_rd_ready = rd_ready; o_wr_ready = wr_ready; o_rsp_valid = rsp_valid;
    o_rsp_data = rsp_data; o_we0 = mem_we0;
    o_acc_rd = rv && rd_ready; o_acc_wr = wv && wr_ready;
    m_acc_rd = rv && e_rd_ready; m_acc_wr = wv && e_wr_ready;
    if (m_acc_wr) begin ref_mem[wa] = wd; m_last_rd = 1'b0; end
    if (m_acc_rd) begin
      exp_q.push_back('{now + RSP_LAT, ref_mem[ra]});
      m_credits--; m_last_rd = 1'b1;
    end
    if (e_rsp_valid && pr) begin void'(exp_q.pop_front()); m_credits++; end
    @(posedge clk); @(negedge clk);
    now++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; rd_valid = 0; wr_valid = 0; rsp_ready = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    model_reset();
  endtask

  task automatic drain();
    repeat (12) cycle(0, 0, 0, 0, '0, 1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rd_valid = 1; wr_valid = 1; rsp_ready = 1;
    rd_addr = 0; wr_addr = 0; wr_data = '1;
    repeat (2) @(negedge clk);
    #1;
    tests++; if ({wr_ready, rd_ready, rsp_valid, mem_ce0, mem_we0} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 00000", {wr_ready, rd_ready, rsp_valid, mem_ce0, mem_we0});
    end
    tests++; if (mem_address0 !== 11'd0) begin fails++; $display("FAIL reset_addr: got %0h expected 0", mem_address0); end
    tests++; if (mem_d0 !== 256'd0) begin fails++; $display("FAIL reset_d0: got %0h expected 0", mem_d0); end
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    model_reset(); now = 0;
    #1;
    tests++; if ({rd_ready, wr_ready} !== 2'b10) begin
      fails++; $display("FAIL post_reset_ready: got %b expected 10", {rd_ready, wr_ready});
    end
    rd_valid = 0; wr_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [255:0] pat = {32{8'hA5}};
    logic [255:0] got = '0;
    int c_acc, c_rsp = -1, we_cnt = 0, t;
    cycle(0, 0, 1, 11'd5, pat, 1); we_cnt += int'(o_we0);
    tests++; if (o_acc_wr !== 1'b1) begin fails++; $display("FAIL wr_accept: got %b expected 1", o_acc_wr); end
    c_acc = now;
    cycle(1, 11'd5, 0, 0, '0, 1); we_cnt += int'(o_we0);
    tests++; if (o_acc_rd !== 1'b1) begin fails++; $display("FAIL rd_accept: got %b expected 1", o_acc_rd); end
    for (int i = 0; i < 10; i++) begin
      t = now;
      cycle(0, 0, 0, 0, '0, 1); we_cnt += int'(o_we0);
      if (o_rsp_valid && c_rsp < 0) begin c_rsp = t; got = o_rsp_data; end
    end
    tests++; if (c_rsp != c_acc + 4) begin fails++; $display("FAIL raw_latency: got %0d expected %0d", c_rsp, c_acc + 4); end
    tests++; if (got !== pat) begin fails++; $display("FAIL raw_data: got %0h expected %0h", got, pat); end
    tests++; if (we_cnt != 1) begin fails++; $display("FAIL we0_pulses: got %0d expected 1", we_cnt); end
  endtask

  task automatic test_back_to_back();
    int idx = 0, got = 0;
    for (int i = 0; i < 16; i++) begin
      b2b[i] = rnd256();
      cycle(0, 0, 1, 11'(i), b2b[i], 1);
      tests++; if (o_acc_wr !== 1'b1) begin fails++; $display("FAIL prefill_accept %0d: got %b expected 1", i, o_acc_wr); end
    end
    for (int k = 0; k < 60 && got < 16; k++) begin
      cycle(idx < 16, 11'(idx), 0, 0, '0, 1);
      tests++; if (o_rd_ready !== e_rd_ready) begin fails++; $display("FAIL b2b_rd_ready %0d: got %b expected %b", k, o_rd_ready, e_rd_ready); end
      tests++; if (o_rsp_valid !== e_rsp_valid) begin fails++; $display("FAIL b2b_rsp_valid %0d: got %b expected %b", k, o_rsp_valid, e_rsp_valid); end
      if (m_acc_rd) idx++;
      if (o_rsp_valid && got < 16) begin
        tests++; if (o_rsp_data !== b2b[got]) begin fails++; $display("FAIL b2b_order %0d: got %0h expected %0h", got, o_rsp_data, b2b[got]); end
        got++;
      end
    end
    tests++; if (got != 16) begin fails++; $display("FAIL b2b_timeout: got %0d responses expected 16", got); end
    drain();
  endtask

  task automatic test_arbitration();
    int n_rd = 0, n_wr = 0, m_rd = 0, m_wr = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1, 11'(i), 1, 11'(32 + i), rnd256(), 1);
      n_rd += int'(o_acc_rd); n_wr += int'(o_acc_wr);
      m_rd += int'(m_acc_rd); m_wr += int'(m_acc_wr);
      tests++; if ({o_acc_rd, o_acc_wr} !== {m_acc_rd, m_acc_wr}) begin
        fails++; $display("FAIL arb_grant %0d: got rd/wr %b%b expected %b%b", i, o_acc_rd, o_acc_wr, m_acc_rd, m_acc_wr);
      end
`ifdef KNN_ARB_RR_EN
      tests++; if (o_acc_rd !== (i % 2 == 0)) begin fails++; $display("FAIL rr_alternate %0d: got rd %b expected %b", i, o_acc_rd, (i % 2 == 0)); end
`endif
      if (e_rsp_valid) begin
        tests++; if (o_rsp_data !== e_rsp_data) begin fails++; $display("FAIL arb_rsp_data %0d: got %0h expected %0h", i, o_rsp_data, e_rsp_data); end
      end
    end
    tests++; if (n_rd != m_rd || n_wr != m_wr) begin
      fails++; $display("FAIL arb_counts: got %0d reads %0d writes expected %0d reads %0d writes", n_rd, n_wr, m_rd, m_wr);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n_acc = 0, got = 0, first_pop = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 11'(i), 0, 0, '0, 0);
      n_acc += int'(o_acc_rd);
    end
    tests++; if (n_acc != DEPTH) begin fails++; $display("FAIL bp_accepts: got %0d expected %0d", n_acc, DEPTH); end
    tests++; if (o_rd_ready !== 1'b0) begin fails++; $display("FAIL bp_rd_ready_low: got %b expected 0", o_rd_ready); end
    for (int k = 0; k < 20; k++) begin
      cycle(1, 11'd8, 0, 0, '0, 1);
      if (first_pop >= 0 && k == first_pop + 1) begin
        tests++; if (o_rd_ready !== 1'b1) begin fails++; $display("FAIL bp_reassert: got %b expected 1", o_rd_ready); end
      end
      if (o_rsp_valid && first_pop < 0) begin
        first_pop = k;
        tests++; if (o_rd_ready !== 1'b0) begin fails++; $display("FAIL bp_pop_cycle_ready: got %b expected 0", o_rd_ready); end
      end
      tests++; if (o_rsp_valid !== e_rsp_valid) begin fails++; $display("FAIL bp_rsp_valid %0d: got %b expected %b", k, o_rsp_valid, e_rsp_valid); end
      if (o_rsp_valid && got < 4) begin
        tests++; if (o_rsp_data !== b2b[got]) begin fails++; $display("FAIL bp_order %0d: got %0h expected %0h", got, o_rsp_data, b2b[got]); end
        got++;
      end
    end
    tests++; if (got != 4) begin fails++; $display("FAIL bp_timeout: got %0d responses expected 4", got); end
    drain();
  endtask

  task automatic test_reset_inflight();
    int n_acc = 0;
    for (int i = 1; i <= 3; i++) cycle(1, 11'(i), 0, 0, '0, 1);
    reset_n = 1'b0; rd_valid = 0; wr_valid = 0;
    #1;
    tests++; if ({mem_ce0, mem_we0, rd_ready, wr_ready, rsp_valid} !== 5'b0) begin
      fails++; $display("FAIL rst_mid_ctrl: got %b expected 00000", {mem_ce0, mem_we0, rd_ready, wr_ready, rsp_valid});
    end
    tests++; if (mem_address0 !== 11'd0 || mem_d0 !== 256'd0) begin
      fails++; $display("FAIL rst_mid_bus: got addr %0h d0 %0h expected 0 0", mem_address0, mem_d0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    model_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 0, '0, 1);
      tests++; if (o_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_stale_rsp %0d: got %b expected 0", k, o_rsp_valid); end
    end
    for (int k = 0; k < 6; k++) begin
      cycle(1, 11'(k), 0, 0, '0, 0);
      n_acc += int'(o_acc_rd);
    end
    tests++; if (n_acc != DEPTH) begin fails++; $display("FAIL rst_credits: got %0d accepts expected %0d", n_acc, DEPTH); end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 2) != 0, 11'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            11'($urandom_range(0, 15)), rnd256(), $urandom_range(0, 3) != 0);
      tests++; if (o_rd_ready !== e_rd_ready) begin fails++; $display("FAIL rand_rd_ready %0d: got %b expected %b", k, o_rd_ready, e_rd_ready); end
      tests++; if (o_wr_ready !== e_wr_ready) begin fails++; $display("FAIL rand_wr_ready %0d: got %b expected %b", k, o_wr_ready, e_wr_ready); end
      tests++; if (o_rsp_valid !== e_rsp_valid) begin fails++; $display("FAIL rand_rsp_valid %0d: got %b expected %b", k, o_rsp_valid, e_rsp_valid); end
      if (e_rsp_valid) begin
        tests++; if (o_rsp_data !== e_rsp_data) begin fails++; $display("FAIL rand_rsp_data %0d: got %0h expected %0h", k, o_rsp_data, e_rsp_data); end
      end
    end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_addr = 0; wr_addr = 0; wr_data = '0; now = 0;
    model_reset();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_arbitration();
    test_backpressure();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
